ringbus_tx: RTL and testbench
=============================

RINGBUS_TX -- requirements
Module: ringbus_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal values are 1 or greater.
REQ-002 SHALL have parameter GAP_BITS, default 2: number of idle bit-times after the stop bit; legal values are 1 or greater.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_data, input, 32 bits: word to transmit.
REQ-006 SHALL have port i_valid, input, 1 bit: i_data is valid.
REQ-007 SHALL have port o_ready, output, 1 bit: the block accepts a word on the next rising edge.
REQ-008 SHALL have port o_ringbus, output, 1 bit: registered serial ringbus line.
REQ-009 SHALL have port o_busy, output, 1 bit: a frame or inter-frame gap is in progress.

Function
REQ-010 SHALL transfer a word on a rising edge where i_valid and o_ready are both 1; no other edge transfers data.
REQ-011 SHALL capture i_data into an internal shift register on the accepting edge; i_data changes after acceptance have no effect on the frame.
REQ-012 SHALL hold o_ringbus at 0 while idle.
REQ-013 SHALL send each frame in this fixed order:
- start bit = 1;
- 32 data bits, LSB first;
- parity bit = XOR of all 32 data bits (even parity);
- stop bit = 0;
- GAP_BITS idle bits = 0.
REQ-014 SHALL hold each bit on o_ringbus for exactly CLKS_PER_BIT cycles.
REQ-015 SHALL drive the start bit on o_ringbus in the first cycle after the accepting edge, because o_ringbus is registered.
REQ-016 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP and GAP.
REQ-017 SHALL follow these FSM transitions:
- IDLE to START on accept;
- START to DATA, DATA to PARITY, PARITY to STOP, STOP to GAP, each after one bit-time;
- DATA to PARITY only after the 32nd bit;
- GAP to IDLE after GAP_BITS bit-times.
REQ-018 SHALL drive o_ready as a register that is 1 only in IDLE.
REQ-019 SHALL clear o_ready on the accepting edge.
REQ-020 SHALL set o_ready again exactly (35+GAP_BITS)*CLKS_PER_BIT cycles after the accepting edge.
REQ-021 SHALL drive o_busy as the inverse of (state==IDLE), registered.
REQ-022 SHALL size the bit-time counter to ceil(log2(CLKS_PER_BIT)) bits, with a minimum of 1 bit, and wrap it to 0 at CLKS_PER_BIT-1.
REQ-023 SHALL size the data-bit counter to 5 bits and compare it against 31.
REQ-024 SHALL, when CLKS_PER_BIT=1, advance one bit per clock with no idle cycles inside the frame.
REQ-025 SHALL, when i_valid is held high continuously, accept back-to-back words exactly every (35+GAP_BITS)*CLKS_PER_BIT cycles.
REQ-026 SHALL, when i_valid is asserted while o_ready is 0, neither transfer the word nor disturb the frame in progress.

Reset
REQ-027 SHALL, while reset is asserted, immediately force:
- state = IDLE;
- o_ringbus = 0;
- o_ready = 0;
- o_busy = 0;
- all counters and the shift register = 0.
REQ-028 SHALL assert o_ready on the first rising edge after reset deasserts.
REQ-029 SHALL abandon a frame truncated by reset with no resumption; the next accepted word sends a complete new frame.

Structure
REQ-030 SHALL place the following in shared package ringbus_pkg, for reuse by the matching receiver:
- the FSM state enum;
- RB_WORD_BITS=32;
- RB_IDLE_LEVEL=0, RB_START_LEVEL=1, RB_STOP_LEVEL=0;
- RB_OVERHEAD_BITS=3.
REQ-031 SHALL implement the bit-time counter in one sub-module, ringbus_bit_tick (parameter CLKS_PER_BIT; outputs a one-cycle tick at the end of each bit).

Verification
REQ-032 SHALL cover reset: assert reset for 5 cycles with i_valid=1 -> o_ringbus=0 and o_ready=0 throughout; o_ready=1 one edge after release.
REQ-033 SHALL cover a single word at default parameters: i_data=0x00000001 -> the following levels, each held 4 cycles, then o_ready=1 at 148 cycles after accept:
- start = 1;
- bit0 = 1;
- 31 zero bits;
- parity = 1;
- stop = 0;
- 8 cycles of 0.
REQ-034 SHALL cover parity: i_data=0xA5A5A5A5 (16 ones) -> parity bit 0; i_data=0x80000000 -> final data bit 1 and parity 1.
REQ-035 SHALL cover streaming: i_valid held high with words 0x12345678 then 0xDEADBEEF -> second accept exactly 148 cycles after the first; i_data toggled during frame 1 does not corrupt frame 1.
REQ-036 SHALL cover reset mid-frame: assert reset during data bit 10 of 0xFFFFFFFF -> o_ringbus=0 asynchronously; after release, word 0x0000000F sends a complete correct frame.
REQ-037 SHALL cover the minimum-timing boundary: CLKS_PER_BIT=1, GAP_BITS=1 -> frame period 36 cycles; captured bits match 0xCAFEF00D LSB-first.

Source files
------------

// File: rtl/ringbus_pkg.sv
// ringbus_pkg: framing constants and FSM state type shared by the ringbus
// transmitter and the matching receiver.
`default_nettype none

package ringbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } rb_state_e;

  localparam int   RB_WORD_BITS     = 32;
  localparam logic RB_IDLE_LEVEL    = 1'b0;
  localparam logic RB_START_LEVEL   = 1'b1;
  localparam logic RB_STOP_LEVEL    = 1'b0;
  localparam int   RB_OVERHEAD_BITS = 3;

endpackage

`default_nettype wire

// File: rtl/ringbus_bit_tick.sv
// ringbus_bit_tick: bit-time counter; o_tick pulses in the last cycle of each
// bit while enabled.
`default_nettype none

module ringbus_bit_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign o_tick = i_en && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ringbus_tx.sv
// ringbus_tx: serialises 32-bit words onto the ringbus line as
// start / 32 data bits LSB first / even parity / stop / idle gap.
`default_nettype none

module ringbus_tx
  import ringbus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_BITS     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_ringbus,
  output logic        o_busy
);

  // The last gap cycle is spent in IDLE with o_ready high, so a waiting word
  // is accepted exactly one frame period after the previous one.
  localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W      = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
  localparam logic [4:0] LAST_BIT = 5'(RB_WORD_BITS - 1);

  rb_state_e   state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic        parity_q, parity_d;
  logic        ready_q, ready_d;
  logic        ringbus_q, ringbus_d;
  logic        busy_q, busy_d;
  logic        accept;
  logic        tick;
  logic        tick_clear;

  assign tick_clear = (state_q == ST_IDLE);

  ringbus_bit_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_tick (
    .clk    (clk),
    .reset  (reset),
    .i_clear(tick_clear),
    .i_en   (!tick_clear),
    .o_tick (tick)
  );

  always_comb begin
    accept    = i_valid && ready_q;
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    parity_d  = parity_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_START;
          shift_d   = i_data;
          parity_d  = ^i_data;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            shift_d   = {1'b0, shift_q[31:1]};
          end
        end
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick) begin
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES > 1) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the next state so the start bit appears right after accept.
    case (state_d)
      ST_START:  ringbus_d = RB_START_LEVEL;
      ST_DATA:   ringbus_d = shift_d[0];
      ST_PARITY: ringbus_d = parity_d;
      ST_STOP:   ringbus_d = RB_STOP_LEVEL;
      default:   ringbus_d = RB_IDLE_LEVEL;
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      parity_q  <= 1'b0;
      ready_q   <= 1'b0;
      ringbus_q <= RB_IDLE_LEVEL;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      parity_q  <= parity_d;
      ready_q   <= ready_d;
      ringbus_q <= ringbus_d;
      busy_q    <= busy_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_ringbus = ringbus_q;
  assign o_busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ringbus_tx.sv
// tb_ringbus_tx: drives ringbus_tx at default timing and at the 1-clock/1-gap
// corner, comparing every line cycle against a frame model.
`default_nettype none

module tb_ringbus_tx;

  localparam int C_DEF = 4;
  localparam int G_DEF = 2;
  localparam int C_MIN = 1;
  localparam int G_MIN = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] d_def = '0;
  logic [31:0] d_min = '0;
  logic        v_def = 1'b0;
  logic        v_min = 1'b0;
  logic        rdy_def, line_def, busy_def;
  logic        rdy_min, line_min, busy_min;

  int          compared = 0;
  int          mismatched = 0;
  longint      cyc = 0;
  longint      acc_def[$];
  longint      acc_min[$];
  logic        exp_q[$];
  logic [31:0] w_rand;

  always #5 clk = ~clk;

  ringbus_tx #(.CLKS_PER_BIT(C_DEF), .GAP_BITS(G_DEF)) dut (
    .clk(clk), .reset(reset), .i_data(d_def), .i_valid(v_def),
    .o_ready(rdy_def), .o_ringbus(line_def), .o_busy(busy_def)
  );

  ringbus_tx #(.CLKS_PER_BIT(C_MIN), .GAP_BITS(G_MIN)) dut_min (
    .clk(clk), .reset(reset), .i_data(d_min), .i_valid(v_min),
    .o_ready(rdy_min), .o_ringbus(line_min), .o_busy(busy_min)
  );

  // Handshake observer: records the cycle number of every accepting edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && v_def && rdy_def) acc_def.push_back(cyc);
    if (!reset && v_min && rdy_min) acc_min.push_back(cyc);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rdy(input int sel);
    return (sel != 0) ? rdy_min : rdy_def;
  endfunction

  function automatic logic get_line(input int sel);
    return (sel != 0) ? line_min : line_def;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy_min : busy_def;
  endfunction

  function automatic logic get_valid(input int sel);
    return (sel != 0) ? v_min : v_def;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [31:0] d);
    if (sel != 0) begin
      v_min = v;
      d_min = d;
    end else begin
      v_def = v;
      d_def = d;
    end
  endtask

  // Expected line level for each cycle following the accepting edge.
  task automatic build_frame(input logic [31:0] w, input int c, input int g);
    logic b[$];
    exp_q.delete();
    b.push_back(1'b1);
    for (int i = 0; i < 32; i++) b.push_back(w[i]);
    b.push_back(($countones(w) % 2) == 1);
    b.push_back(1'b0);
    for (int i = 0; i < g; i++) b.push_back(1'b0);
    foreach (b[i]) for (int j = 0; j < c; j++) exp_q.push_back(b[i]);
  endtask

  task automatic run_frame(input int sel, input logic [31:0] w, input bit hold,
                           input logic [31:0] nxt, input bit toggle);
    int n = 0;
    int p;
    build_frame(w, (sel != 0) ? C_MIN : C_DEF, (sel != 0) ? G_MIN : G_DEF);
    p = exp_q.size();
    while (get_rdy(sel) !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_wait s%0d", sel), get_rdy(sel), 1);
    drive(sel, 1'b1, w);
    for (int k = 1; k <= p; k++) begin
      @(negedge clk);
      check($sformatf("line s%0d w%08h k%0d", sel, w, k), get_line(sel), exp_q[k-1]);
      if (k == 1) begin
        check($sformatf("busy_start s%0d", sel), get_busy(sel), 1);
        check($sformatf("ready_low s%0d", sel), get_rdy(sel), 0);
        if (!hold) drive(sel, 1'b0, w);
      end
      if (k == p - 1) check($sformatf("ready_early s%0d", sel), get_rdy(sel), 0);
      if (k == p) begin
        check($sformatf("ready_back s%0d", sel), get_rdy(sel), 1);
        check($sformatf("busy_end s%0d", sel), get_busy(sel), 0);
        if (hold) drive(sel, 1'b1, nxt);
      end else if (toggle && k > 1) begin
        drive(sel, get_valid(sel), $urandom);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b1, $urandom);
    drive(1, 1'b1, $urandom);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_line", line_def, 0);
      check("rst_ready", rdy_def, 0);
      check("rst_busy", busy_def, 0);
      check("rst_line_min", line_min, 0);
      check("rst_ready_min", rdy_min, 0);
    end
    drive(0, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", rdy_def, 1);
    check("ready_after_rst_min", rdy_min, 1);

    run_frame(0, 32'h0000_0001, 1'b0, 32'h0, 1'b0);
    run_frame(0, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0);
    run_frame(0, 32'h8000_0000, 1'b0, 32'h0, 1'b0);

    run_frame(0, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b1);
    run_frame(0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    if (acc_def.size() >= 2)
      check("stream_interval", acc_def[acc_def.size()-1] - acc_def[acc_def.size()-2],
            (35 + G_DEF) * C_DEF);
    else
      check("stream_accepts", acc_def.size(), 2);

    for (int i = 0; i < 3; i++) run_frame(0, $urandom, 1'b0, 32'h0, 1'b0);

    // Reset in the middle of data bit 10 of an all-ones word.
    drive(0, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(0, 1'b0, 32'h0);
    repeat (45) @(negedge clk);
    check("midframe_bit10", line_def, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_line", line_def, 0);
    check("async_rst_ready", rdy_def, 0);
    check("async_rst_busy", busy_def, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_midrst", rdy_def, 1);
    check("line_after_midrst", line_def, 0);
    run_frame(0, 32'h0000_000F, 1'b0, 32'h0, 1'b0);

    w_rand = $urandom;
    run_frame(1, 32'hCAFE_F00D, 1'b1, w_rand, 1'b0);
    run_frame(1, w_rand, 1'b0, 32'h0, 1'b1);
    if (acc_min.size() >= 2)
      check("min_interval", acc_min[acc_min.size()-1] - acc_min[acc_min.size()-2],
            (35 + G_MIN) * C_MIN);
    else
      check("min_accepts", acc_min.size(), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
